// File: rtl/hv_row_server_if.sv
// Request and load bus between a spatial-encoder modality port, the host loader
// and hv_row_server. Outputs of the server are inputs of the master and vice versa.
interface hv_row_server_if #(
  parameter int HV_DIMENSION = 2000,
  parameter int ADDR_WIDTH   = 5
);
  // encoder request side
  logic                    ReqValid_SI;
  logic                    ReqReady_SI;
  logic [ADDR_WIDTH-1:0]   Addr_DI;
  logic                    Valid_SO;
  logic                    Ready_SO;
  logic [0:HV_DIMENSION-1] ItemOut_DO;
  logic [0:HV_DIMENSION-1] ProjNegOut_DO;
  logic [0:HV_DIMENSION-1] ProjPosOut_DO;

  // host load side
  logic                    LoadStart_SI;
  logic                    LoadDone_SI;
  logic                    LoadValid_SI;
  logic                    LoadReady_SO;
  logic [1:0]              LoadSel_DI;
  logic [ADDR_WIDTH-1:0]   LoadAddr_DI;
  logic [0:HV_DIMENSION-1] LoadData_DI;

  modport master (
    output ReqValid_SI, ReqReady_SI, Addr_DI,
    input  Valid_SO, Ready_SO, ItemOut_DO, ProjNegOut_DO, ProjPosOut_DO,
    output LoadStart_SI, LoadDone_SI, LoadValid_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    input  LoadReady_SO
  );

  modport slave (
    input  ReqValid_SI, ReqReady_SI, Addr_DI,
    output Valid_SO, Ready_SO, ItemOut_DO, ProjNegOut_DO, ProjPosOut_DO,
    input  LoadStart_SI, LoadDone_SI, LoadValid_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    output LoadReady_SO
  );
endinterface

// File: rtl/hv_row_server.sv
// Per-modality row server: item memory plus negative/positive projection rows, served
// through a tagged output register. Define HV_ROW_PREFETCH_EN for next-row prefetch.
module hv_row_server #(
  parameter int HV_DIMENSION = 2000,
  parameter int ROWS         = 32,
  parameter int ADDR_WIDTH   = 5
) (
  input logic          Clk_CI,
  input logic          Reset_RBI,
  hv_row_server_if.slave bus
);

  localparam int NMEM = 3;
  localparam int AW1  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] ROWS_W = AW1'(ROWS);

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                state_reg;
  logic                  ready_reg;
  logic [ADDR_WIDTH-1:0] tag_reg;
  logic                  tag_valid_reg;

  logic                  serving;
  logic                  hit;
  logic                  req_in_range;
  logic                  load_ready;
  logic                  wr_acc;
  logic                  wr_in_range;
  logic                  fetch;
  logic                  prefetch;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign serving      = (state_reg == SERVE);
  assign hit          = tag_valid_reg && (tag_reg == bus.Addr_DI);
  assign req_in_range = ({1'b0, bus.Addr_DI} < ROWS_W);
  assign wr_in_range  = ({1'b0, bus.LoadAddr_DI} < ROWS_W);

  // Encoder requests win over host writes while serving.
  assign load_ready = !serving || !bus.ReqValid_SI;
  assign wr_acc     = bus.LoadValid_SI && load_ready;

  assign fetch = serving && bus.ReqValid_SI && !hit && req_in_range && !bus.LoadStart_SI;

`ifdef HV_ROW_PREFETCH_EN
  logic                accept;
  logic [ADDR_WIDTH:0] next_addr;

  assign accept    = serving && bus.ReqValid_SI && hit && bus.ReqReady_SI;
  assign next_addr = {1'b0, bus.Addr_DI} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  // The last row does not wrap: the register keeps row ROWS-1 after its Accept.
  assign prefetch  = accept && (next_addr < ROWS_W) && !bus.LoadStart_SI;
  assign rd_addr   = prefetch ? next_addr[ADDR_WIDTH-1:0] : bus.Addr_DI;
`else
  assign prefetch  = 1'b0;
  assign rd_addr   = bus.Addr_DI;
`endif

  assign rd_en = fetch || prefetch;

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state_reg     <= LOAD;
      ready_reg     <= 1'b0;
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.LoadDone_SI) begin
            state_reg <= SERVE;
            ready_reg <= 1'b1;
          end
        end
        SERVE: begin
          if (bus.LoadStart_SI) begin
            state_reg <= LOAD;
            ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= LOAD;
          ready_reg <= 1'b0;
        end
      endcase

      if (rd_en) begin
        tag_reg       <= rd_addr;
        tag_valid_reg <= 1'b1;
      end
      // Any write may alter the held row, so the register must refetch.
      if (wr_acc || (serving && bus.LoadStart_SI)) begin
        tag_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NMEM; gi++) begin : g_mem
      logic [0:HV_DIMENSION-1] mem [ROWS];
      logic [0:HV_DIMENSION-1] row_reg;
      logic                    wr_en;

      assign wr_en = wr_acc && wr_in_range && (bus.LoadSel_DI == 2'(gi));

      always_ff @(posedge Clk_CI) begin
        if (wr_en) begin
          mem[bus.LoadAddr_DI] <= bus.LoadData_DI;
        end
      end

      always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
          row_reg <= '0;
        end else if (rd_en) begin
          row_reg <= mem[rd_addr];
        end
      end
    end
  endgenerate

  assign bus.ItemOut_DO    = g_mem[0].row_reg;
  assign bus.ProjNegOut_DO = g_mem[1].row_reg;
  assign bus.ProjPosOut_DO = g_mem[2].row_reg;

  assign bus.Valid_SO     = serving && bus.ReqValid_SI && hit;
  assign bus.Ready_SO     = ready_reg;
  assign bus.LoadReady_SO = load_ready;

endmodule

// File: tb/tb_hv_row_server.sv
// Directed bench for hv_row_server: a memory/state model plus a per-cycle compare process,
// and hand-computed latency and data expectations.
module tb_hv_row_server;

  localparam int HVD  = 2000;
  localparam int ROWS = 32;
  localparam int AW   = 5;

`ifdef HV_ROW_PREFETCH_EN
  localparam int EXP_STREAM = 33;
`else
  localparam int EXP_STREAM = 64;
`endif

  typedef logic [0:HVD-1] row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hv_row_server_if #(.HV_DIMENSION(HVD), .ADDR_WIDTH(AW)) bus ();

  hv_row_server #(.HV_DIMENSION(HVD), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .Clk_CI   (clk),
    .Reset_RBI(rst_n),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string name, input row_t act, input row_t exp);
    chk(name, act === exp, act[0:31], exp[0:31]);
  endtask

  function automatic row_t item_pat(input int r);
    logic [4:0] r5;
    r5 = r[4:0];
    return {(HVD/5){r5}};
  endfunction

  function automatic row_t pat(input int sel, input int r);
    row_t ones;
    ones = '1;
    case (sel)
      0:       return item_pat(r);
      1:       return ~item_pat(r);
      default: return item_pat(r) ^ (ones >> 1);
    endcase
  endfunction

  // Model: host-visible state and memory contents from the interface rules.
  row_t m_mem [3][ROWS];
  logic m_serve;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_serve <= 1'b0;
    end else begin
      if (!m_serve && bus.LoadDone_SI) m_serve <= 1'b1;
      else if (m_serve && bus.LoadStart_SI) m_serve <= 1'b0;
      if (bus.LoadValid_SI && (!m_serve || !bus.ReqValid_SI) && bus.LoadSel_DI != 2'd3)
        m_mem[int'(bus.LoadSel_DI)][int'(bus.LoadAddr_DI)] <= bus.LoadData_DI;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready_state", bus.Ready_SO === m_serve, 32'(bus.Ready_SO), 32'(m_serve));
      chk("load_ready", bus.LoadReady_SO === (!m_serve || !bus.ReqValid_SI),
          32'(bus.LoadReady_SO), 32'(!m_serve || !bus.ReqValid_SI));
      if (!m_serve || !bus.ReqValid_SI || !rst_n)
        chk("valid_idle", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
      if (bus.Valid_SO === 1'b1) begin
        chk_row("model_item", bus.ItemOut_DO, m_mem[0][int'(bus.Addr_DI)]);
        chk_row("model_neg", bus.ProjNegOut_DO, m_mem[1][int'(bus.Addr_DI)]);
        chk_row("model_pos", bus.ProjPosOut_DO, m_mem[2][int'(bus.Addr_DI)]);
      end
      if (!rst_n) begin
        chk_row("rst_item", bus.ItemOut_DO, '0);
        chk_row("rst_neg", bus.ProjNegOut_DO, '0);
        chk_row("rst_pos", bus.ProjPosOut_DO, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int sel, input int addr, input row_t data);
    bus.LoadValid_SI = 1'b1;
    bus.LoadSel_DI   = 2'(sel);
    bus.LoadAddr_DI  = AW'(addr);
    bus.LoadData_DI  = data;
    step();
    bus.LoadValid_SI = 1'b0;
    $display("write sel=%0d addr=%0d data[0:31]=%h", sel, addr, data[0:31]);
  endtask

  task automatic expect_miss_then_hit(input string name, input row_t exp_item);
    @(negedge clk);
    chk({name, "_miss"}, bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
    step();
    @(negedge clk);
    chk({name, "_hit"}, bus.Valid_SO === 1'b1, 32'(bus.Valid_SO), 32'd1);
    chk_row({name, "_item"}, bus.ItemOut_DO, exp_item);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t newd;
    row_t junk;
    int   cycles;
    int   acc;
    bit   v;
    logic [4:0] s5;

    bus.ReqValid_SI  = 1'b0;
    bus.ReqReady_SI  = 1'b0;
    bus.Addr_DI      = '0;
    bus.LoadStart_SI = 1'b0;
    bus.LoadDone_SI  = 1'b0;
    bus.LoadValid_SI = 1'b0;
    bus.LoadSel_DI   = '0;
    bus.LoadAddr_DI  = '0;
    bus.LoadData_DI  = '0;
    newd = {(HVD/16){16'hC3A5}};
    junk = {(HVD/16){16'h5AF0}};

    // Reset and LOAD state
    repeat (2) step();
    cmp_en = 1;
    rst_n  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("load_valid", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
      chk("load_ready_so", bus.Ready_SO === 1'b0, 32'(bus.Ready_SO), 32'd0);
      chk("load_loadready", bus.LoadReady_SO === 1'b1, 32'(bus.LoadReady_SO), 32'd1);
      chk_row("load_item_zero", bus.ItemOut_DO, '0);
    end
    step();

    // Load all three memories
    for (int r = 0; r < ROWS; r++)
      for (int s = 0; s < 3; s++)
        write_row(s, r, pat(s, r));

    bus.LoadDone_SI = 1'b1;
    step();
    bus.LoadDone_SI = 1'b0;
    bus.ReqValid_SI = 1'b1;
    bus.Addr_DI     = 5'd0;
    @(negedge clk);
    chk("serve_ready", bus.Ready_SO === 1'b1, 32'(bus.Ready_SO), 32'd1);
    chk("first_miss", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
    step();
    @(negedge clk);
    chk("first_hit", bus.Valid_SO === 1'b1, 32'(bus.Valid_SO), 32'd1);
    chk_row("row0_item", bus.ItemOut_DO, '0);
    s5 = bus.ProjNegOut_DO[0:4];
    chk("row0_neg_lit", s5 === 5'b11111, 32'(s5), 32'h1f);
    s5 = bus.ProjPosOut_DO[0:4];
    chk("row0_pos_lit", s5 === 5'b01111, 32'(s5), 32'h0f);

    step();
    bus.Addr_DI = 5'd3;
    @(negedge clk);
    chk("row3_miss", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
    step();
    @(negedge clk);
    chk("row3_hit", bus.Valid_SO === 1'b1, 32'(bus.Valid_SO), 32'd1);
    s5 = bus.ItemOut_DO[0:4];
    chk("row3_item_lit", s5 === 5'b00011, 32'(s5), 32'h03);
    s5 = bus.ProjNegOut_DO[0:4];
    chk("row3_neg_lit", s5 === 5'b11100, 32'(s5), 32'h1c);
    s5 = bus.ProjPosOut_DO[0:4];
    chk("row3_pos_lit", s5 === 5'b01100, 32'(s5), 32'h0c);

    // Select 3 write: discarded, but invalidates the held row
    step();
    bus.ReqValid_SI = 1'b0;
    write_row(3, 0, junk);

    // Sequential stream 0..31
    bus.ReqValid_SI = 1'b1;
    bus.ReqReady_SI = 1'b1;
    bus.Addr_DI     = 5'd0;
    cycles = 0;
    acc    = 0;
    while (acc < ROWS && cycles < 200) begin
      @(negedge clk);
      cycles++;
      v = bus.Valid_SO;
      if (v) begin
        s5 = bus.ItemOut_DO[0:4];
        chk("stream_row", s5 === bus.Addr_DI, 32'(s5), 32'(bus.Addr_DI));
        $display("accept addr=%0d cycle=%0d", bus.Addr_DI, cycles);
      end
      step();
      if (v) begin
        acc++;
        bus.Addr_DI = bus.Addr_DI + 5'd1;
      end
    end
    chk("stream_accepts", acc == ROWS, 32'(acc), 32'(ROWS));
    chk("stream_cycles", cycles == EXP_STREAM, 32'(cycles), 32'(EXP_STREAM));

    // Wrap to 0 costs exactly one miss
    bus.ReqReady_SI = 1'b0;
    expect_miss_then_hit("wrap", item_pat(0));

    // Write while serving
    step();
    bus.Addr_DI = 5'd5;
    expect_miss_then_hit("tag5", item_pat(5));
    step();
    bus.ReqValid_SI = 1'b0;
    write_row(0, 5, newd);
    bus.ReqValid_SI = 1'b1;
    expect_miss_then_hit("wr_serve", newd);
    chk_row("wr_serve_neg", bus.ProjNegOut_DO, pat(1, 5));

    // Mid-stream reset
    step();
    bus.Addr_DI = 5'd10;
    expect_miss_then_hit("pre_rst", item_pat(10));
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
    chk("rst_ready", bus.Ready_SO === 1'b0, 32'(bus.Ready_SO), 32'd0);
    chk("rst_loadready", bus.LoadReady_SO === 1'b1, 32'(bus.LoadReady_SO), 32'd1);
    chk_row("rst_now_item", bus.ItemOut_DO, '0);
    chk_row("rst_now_pos", bus.ProjPosOut_DO, '0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.Ready_SO === 1'b0, 32'(bus.Ready_SO), 32'd0);
    step();
    bus.LoadDone_SI = 1'b1;
    step();
    bus.LoadDone_SI = 1'b0;
    @(negedge clk);
    chk("recover_ready", bus.Ready_SO === 1'b1, 32'(bus.Ready_SO), 32'd1);
    chk("recover_miss", bus.Valid_SO === 1'b0, 32'(bus.Valid_SO), 32'd0);
    step();
    @(negedge clk);
    chk("recover_hit", bus.Valid_SO === 1'b1, 32'(bus.Valid_SO), 32'd1);
    chk_row("intact_item", bus.ItemOut_DO, pat(0, 10));
    chk_row("intact_neg", bus.ProjNegOut_DO, pat(1, 10));
    chk_row("intact_pos", bus.ProjPosOut_DO, pat(2, 10));

    // LoadStart returns to LOAD and drops the held row
    step();
    bus.ReqValid_SI  = 1'b0;
    bus.LoadStart_SI = 1'b1;
    step();
    bus.LoadStart_SI = 1'b0;
    @(negedge clk);
    chk("ls_ready", bus.Ready_SO === 1'b0, 32'(bus.Ready_SO), 32'd0);
    chk("ls_loadready", bus.LoadReady_SO === 1'b1, 32'(bus.LoadReady_SO), 32'd1);
    step();
    bus.LoadDone_SI = 1'b1;
    step();
    bus.LoadDone_SI = 1'b0;
    bus.ReqValid_SI = 1'b1;
    bus.Addr_DI     = 5'd10;
    expect_miss_then_hit("ls_refetch", item_pat(10));

    step();
    bus.ReqValid_SI = 1'b0;
    step();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
